// File: rtl/led_driver.sv
// led_driver: per-channel LED output stage with shared PWM dimming,
// activity pulse stretching, blink/on/off modes and a single-cycle
// configuration write port. All outputs are registered.
module led_driver #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned PWM_BITS     = 3,
    parameter int unsigned STRETCH_BITS = 20,
    parameter int unsigned BLINK_BITS   = 23,
    parameter int unsigned RESET_DUTY   = 1,
    localparam int unsigned SEL_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clock_160,
    input  logic                inp_resn,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [1:0]          cfg_mode,
    output logic                cfg_ack,
    output logic [NUM_LEDS-1:0] led_out
);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_OFF    = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_ON     = 2'd3
    } led_mode_e;

    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [BLINK_BITS-1:0]   blink_div;
    logic [NUM_LEDS-1:0]     in_q;
    logic [STRETCH_BITS-1:0] stretch_cnt [NUM_LEDS];
    logic [PWM_BITS-1:0]     duty        [NUM_LEDS];
    led_mode_e               mode        [NUM_LEDS];

    logic                    blink_ph_c;
    logic                    sel_ok_c;
    logic                    cfg_hit_c;
    logic [NUM_LEDS-1:0]     stretched_c;
    logic [NUM_LEDS-1:0]     gate_c;
    logic [NUM_LEDS-1:0]     led_nxt_c;

    assign blink_ph_c = blink_div[BLINK_BITS-1];

    // Out-of-range channel index only exists when NUM_LEDS is not a power of two
    if ((1 << SEL_W) > NUM_LEDS) begin : g_sel_chk
        assign sel_ok_c = (cfg_sel < SEL_W'(NUM_LEDS));
    end else begin : g_sel_full
        assign sel_ok_c = 1'b1;
    end

    assign cfg_hit_c = cfg_we & sel_ok_c;

    // Shared free-running PWM counter and blink divider
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            pwm_cnt   <= '0;
            blink_div <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            blink_div <= blink_div + BLINK_BITS'(1);
        end
    end

    // Input capture and per-channel stretch counters (reload while input high)
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            in_q <= '0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                stretch_cnt[i] <= '0;
            end
        end else begin
            in_q <= led_in;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                if (in_q[i]) begin
                    stretch_cnt[i] <= '1;
                end else if (stretch_cnt[i] != '0) begin
                    stretch_cnt[i] <= stretch_cnt[i] - STRETCH_BITS'(1);
                end
            end
        end
    end

    // Per-channel configuration; a write takes effect on the next compare
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                duty[i] <= PWM_BITS'(RESET_DUTY);
                mode[i] <= MODE_NORMAL;
            end
        end else begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                if (cfg_hit_c && (cfg_sel == SEL_W'(i))) begin
                    duty[i] <= cfg_duty;
                    mode[i] <= led_mode_e'(cfg_mode);
                end
            end
        end
    end

    // Stretch, PWM gate and mode selection per channel
    always_comb begin
        stretched_c = '0;
        gate_c      = '0;
        led_nxt_c   = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            stretched_c[i] = in_q[i] | (stretch_cnt[i] != '0);

            // All-ones duty is forced fully on; the compare alone would drop the last slot
            if (duty[i] == '0) begin
                gate_c[i] = 1'b0;
            end else if (duty[i] == '1) begin
                gate_c[i] = 1'b1;
            end else begin
                gate_c[i] = (pwm_cnt < duty[i]);
            end

            case (mode[i])
                MODE_NORMAL: led_nxt_c[i] = stretched_c[i] & gate_c[i];
                MODE_OFF:    led_nxt_c[i] = 1'b0;
                MODE_BLINK:  led_nxt_c[i] = stretched_c[i] & blink_ph_c & gate_c[i];
                MODE_ON:     led_nxt_c[i] = gate_c[i];
                default:     led_nxt_c[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive and write acknowledge
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            led_out <= '0;
            cfg_ack <= 1'b0;
        end else begin
            led_out <= led_nxt_c;
            cfg_ack <= cfg_hit_c;
        end
    end

endmodule

// File: doc/led_driver.md
# led_driver

Parametrised LED output stage for board top-levels: it replaces the fixed 3-bit dimming counter and hard-wired LED gating with per-channel brightness, mode and pulse stretching. It takes the per-cog activity bits (or any status bits) from the clock_160 domain and drives the board LED pins with registered outputs. Software-free configuration comes through a simple single-cycle write port that top-levels tie off or drive from a switch/debug decoder.

## Interface
- NUM_LEDS, 8: number of LED channels (1..32).
- PWM_BITS, 3: PWM counter width. Brightness period is 2^PWM_BITS cycles.
- STRETCH_BITS, 20: stretch counter width. Minimum visible on-time after an input falls is 2^STRETCH_BITS−1 cycles.
- BLINK_BITS, 23: blink divider width. Blink phase is the divider MSB.
- RESET_DUTY, 1: duty loaded into every channel at reset.
- clock_160  in  1  sole clock.
- inp_resn  in  1  reset, asynchronous, active-low.
- led_in  in  NUM_LEDS  channel status bits, synchronous to clock_160.
- cfg_we  in  1  single-cycle configuration write strobe.
- cfg_sel  in  max(1,$clog2(NUM_LEDS))  channel index for the write.
- cfg_duty  in  PWM_BITS  brightness value to write.
- cfg_mode  in  2  mode to write.
- cfg_ack  out  1  pulses for 1 cycle after an accepted write.
- led_out  out  NUM_LEDS  registered LED drive, active-high.

## Operation
- **PWM counter** pwm_cnt, PWM_BITS wide: free-running, increments every cycle, wraps from all-ones to 0. It is shared by all channels.
- **Blink divider**, BLINK_BITS wide: free-running. blink_ph = MSB.
- **Input register**: led_in is registered once into in_q.
- **Per-channel stretch counter** s[i], STRETCH_BITS wide:
  - in_q[i]=1 → load all-ones.
  - else if s[i]≠0 → decrement.
  - stretched[i] = in_q[i] | (s[i]≠0).
- **PWM gate** g[i] for duty D:
  - D=0 → 0.
  - D=all-ones → 1 (full on).
  - otherwise → (pwm_cnt < D). Duty 1 therefore gives a 1-in-2^PWM_BITS on-time.
- **Modes** (per channel, 2 bits):
  - 0 NORMAL: stretched & g.
  - 1 OFF: 0.
  - 2 BLINK: stretched & blink_ph & g.
  - 3 ON: g, input ignored.
- led_out[i] registers the mode result.
- **Config write**:
  - cfg_we=1 with cfg_sel<NUM_LEDS → duty/mode of channel cfg_sel updated at the next edge, and cfg_ack=1 on the following cycle.
  - cfg_sel≥NUM_LEDS → write ignored, no ack.
  - Back-to-back writes are accepted every cycle. Each accepted write gets its own ack.
- **Reset values**: led_out=0, cfg_ack=0, pwm_cnt=0, blink divider=0, in_q=0, all s[i]=0, all duty=RESET_DUTY, all mode=NORMAL.

## Timing
- led_in edge at clock t → in_q at t+1 → led_out at t+2, provided the gate is open at t+1.
- Stretch behaviour:
  - Input low at t: s[i] is still all-ones at t+1.
  - led_out stays high for a further 2^STRETCH_BITS−1 gate-open cycles.
  - led_out is low from the cycle after s reaches 0.
- Retrigger during stretch reloads all-ones. There is no glitch on led_out.
- Write at edge t:
  - New duty/mode are visible in the led_out computed at edge t+1, i.e. on the output after t+2.
  - cfg_ack is high during the cycle after t+1.
- A write coinciding with pwm_cnt wrap uses the new duty from the next compare. There is no end-of-period buffering, which is intentional.
- Write and input change on the same cycle: both take effect independently, with no ordering dependency.
- Reset asserted mid-operation: all outputs go to 0 immediately (async), and configuration returns to reset values. Deassertion is synchronised externally; the first count occurs on the first edge after release.
- No combinational path from any input to any output.

## Test plan
Use PWM_BITS=3, STRETCH_BITS=3, BLINK_BITS=4, NUM_LEDS=8 throughout.

1. **Reset defaults**: hold led_in=8'hFF after reset release → each led_out high exactly 1 cycle in every 8 (pwm_cnt=0), all channels in phase; cfg_ack stays 0.
2. **Duty sweep**: write ch3 duty 0, then 4, then 7 → ch3 on 0/8, 4/8, 8/8 cycles per period respectively; each write is followed by a single cfg_ack, and the new duty takes effect 2 cycles after the write.
3. **Stretch**: ch0 duty 7, 1-cycle pulse on led_in[0] → led_out[0] high for 8 consecutive cycles, starting 2 cycles after the pulse; a second pulse 4 cycles later extends the high time to 12 cycles total.
4. **Modes**: ch5 duty 7 with led_in[5]=0, mode ON → constantly high. Mode OFF with led_in=1 → constantly 0. Mode BLINK with led_in=1 → 8 cycles high, 8 cycles low, repeating.
5. **Invalid address**: cfg_we with cfg_sel=9 (sel width 3 truncates, so drive cfg_sel=7 plus NUM_LEDS=6 build) → no state change, no cfg_ack.
6. **Async reset**: assert inp_resn low mid-stretch, mid-period, with non-default config → led_out=0 in the same cycle; after release, channels behave as in scenario 1.
